// File: rtl/picorv32_mem_arbiter.sv
// Two-master round-robin arbiter onto a single PicoRV32 native memory port.
// Each transaction locks the bus, and a watchdog force-completes it if the slave never answers.
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        grant,
  output logic        busy,
  output logic        timeout_err,
  output logic        state_dbg
);

  // Handshake: a master raises valid with a stable payload and holds it until
  // its ready pulses for exactly one cycle; the downstream port obeys the same
  // rule, with mem_valid held high from grant until mem_ready or timeout.

  localparam int          CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic pick;
  logic done_ok;
  logic to_fire;
  logic complete;
  logic [31:0] ret_data;

  // On a tie, the master that did not win last time takes the bus.
  assign pick     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
  assign done_ok  = (state_q == BUSY) && mem_ready;
  assign to_fire  = (state_q == BUSY) && !mem_ready && WD_EN && (cnt_q == TO_LAST);
  assign complete = done_ok || to_fire;
  assign ret_data = done_ok ? mem_rdata : ERR_RDATA;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (complete) begin
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid   = 1'b0;
    mem_instr   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    timeout_err = to_fire;
    if (state_q == BUSY) begin
      mem_valid = 1'b1;
      if (grant_q) begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
        m1_ready  = complete;
        m1_rdata  = complete ? ret_data : '0;
      end else begin
        mem_instr = m0_instr;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
        m0_ready  = complete;
        m0_rdata  = complete ? ret_data : '0;
      end
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin/timeout model.
module tb_picorv32_mem_arbiter;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant, busy, timeout_err, state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  picorv32_mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock/reset block: posedge is active, stimulus and sampling at negedge.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    m0_valid = 1; m0_instr = 1; m0_addr = 32'h1111_2222; m0_wstrb = 4'hF; mem_ready = 1;
    @(negedge clk); #1;
    total++;
    if ({busy, mem_valid, m0_ready, m1_ready, timeout_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, mem_valid, m0_ready, m1_ready, timeout_err});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb, mem_instr} !== 69'b0) begin
      bad++; $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h instr=%b want zeros", mem_addr, mem_wdata, mem_wstrb, mem_instr);
    end
    total++;
    if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_release: busy got %b want 0", busy); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 0; m0_instr = 0;
    #1;
    total++;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL single_latency: mem_valid got %b want 0", mem_valid); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      mem_ready = (c == 3);
      mem_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
      #1;
      total++;
      if ({mem_valid, grant, mem_addr} !== {1'b1, 1'b0, 32'h0000_0100}) begin
        bad++; $display("FAIL single_bus c=%0d: got v=%b g=%b a=%h want 1 0 00000100", c, mem_valid, grant, mem_addr);
      end
      total++;
      if ({m0_ready, m1_ready} !== {(c == 3), 1'b0}) begin
        bad++; $display("FAIL single_ready c=%0d: got %b%b want %b0", c, m0_ready, m1_ready, (c == 3));
      end
      if (c == 3) begin
        total++;
        if (m0_rdata !== 32'h1234_5678) begin bad++; $display("FAIL single_rdata: got %h want 12345678", m0_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_done: busy got %b want 0", busy); end
  endtask

  task automatic test_contention();
    logic e;
    resetn = 0;
    idle_inputs();
    m0_valid = 1; m0_instr = 1; m0_addr = 32'hA000_0000;
    m1_valid = 1; m1_addr = 32'hB000_0000;
    repeat (2) @(negedge clk);
    resetn = 1;
    #1;
    for (int t = 0; t < 4; t++) begin
      e = t[0];
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL contend_bubble t=%0d: busy got %b want 0", t, busy); end
      @(negedge clk);
      mem_ready = 1; mem_rdata = 32'(t);
      #1;
      total++;
      if ({grant, mem_instr, mem_addr} !== {e, ~e, (e ? 32'hB000_0000 : 32'hA000_0000)}) begin
        bad++; $display("FAIL contend_grant t=%0d: got g=%b i=%b a=%h want g=%b", t, grant, mem_instr, mem_addr, e);
      end
      total++;
      if ({m0_ready, m1_ready} !== {~e, e}) begin
        bad++; $display("FAIL contend_ready t=%0d: got %b%b want %b%b", t, m0_ready, m1_ready, ~e, e);
      end
      @(negedge clk);
      mem_ready = 0;
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_write_routing();
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h0000_2000; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    @(negedge clk); #1;
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb, grant, mem_instr} !== {32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 1'b1, 1'b0}) begin
      bad++; $display("FAIL write_bus: got a=%h d=%h s=%b g=%b i=%b", mem_addr, mem_wdata, mem_wstrb, grant, mem_instr);
    end
    total++;
    if (m1_ready !== 1'b0) begin bad++; $display("FAIL write_early: m1_ready got %b want 0", m1_ready); end
    @(negedge clk);
    mem_ready = 1;
    #1;
    total++;
    if ({m1_ready, m0_ready} !== 2'b10) begin
      bad++; $display("FAIL write_ready: got m1=%b m0=%b want 1 0", m1_ready, m0_ready);
    end
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h0000_0040;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk); #1;
      total++;
      if ({mem_valid, m0_ready, timeout_err} !== {1'b1, (c == TO), (c == TO)}) begin
        bad++; $display("FAIL timeout_c%0d: got v=%b r=%b te=%b want 1 %b %b", c, mem_valid, m0_ready, timeout_err, (c == TO), (c == TO));
      end
      if (c == TO) begin
        total++;
        if (m0_rdata !== ERR) begin bad++; $display("FAIL timeout_rdata: got %h want %h", m0_rdata, ERR); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    #1;
    total++;
    if ({m0_ready, m1_ready, busy, timeout_err} !== 4'b0) begin
      bad++; $display("FAIL late_ready: got %b want 0000", {m0_ready, m1_ready, busy, timeout_err});
    end
    @(negedge clk);
    mem_ready = 0;
  endtask

  task automatic test_coincidence();
    @(negedge clk);
    m1_valid = 1; m1_addr = 32'h0000_0080;
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      mem_ready = (c == TO);
      mem_rdata = (c == TO) ? 32'h600D_F00D : 32'h0;
      #1;
      total++;
      if ({m1_ready, timeout_err} !== {(c == TO), 1'b0}) begin
        bad++; $display("FAIL coincide_c%0d: got r=%b te=%b want %b 0", c, m1_ready, timeout_err, (c == TO));
      end
      if (c == TO) begin
        total++;
        if (m1_rdata !== 32'h600D_F00D) begin bad++; $display("FAIL coincide_rdata: got %h want 600df00d", m1_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m0_valid = 1; m0_addr = 32'h0000_0300;
    @(negedge clk); #1;
    total++;
    if ({busy, grant} !== 2'b10) begin bad++; $display("FAIL midrst_pre: got busy=%b g=%b want 1 0", busy, grant); end
    @(negedge clk);
    resetn = 0; mem_ready = 1;
    #1;
    total++;
    if ({mem_valid, busy, m0_ready, m1_ready} !== 4'b0) begin
      bad++; $display("FAIL midrst_abort: got %b want 0000", {mem_valid, busy, m0_ready, m1_ready});
    end
    @(negedge clk);
    mem_ready = 0; m1_valid = 1; m1_addr = 32'h0000_0400; resetn = 1;
    #1;
    @(negedge clk); #1;
    total++;
    if ({busy, grant, mem_addr} !== {1'b1, 1'b0, 32'h0000_0300}) begin
      bad++; $display("FAIL midrst_first: got busy=%b g=%b a=%h want 1 0 00000300", busy, grant, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    total++;
    if (m0_ready !== 1'b1) begin bad++; $display("FAIL midrst_done: m0_ready got %b want 1", m0_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  // Model: round-robin choice from pending requests, completion after the
  // slave latency or at the watchdog limit, slave data winning a tie.
  task automatic test_random();
    logic        pend[2];
    logic [31:0] a[2], d[2];
    logic [3:0]  s[2];
    logic        ins, w, lw;
    logic        to;
    int          lat, done_k;
    logic [31:0] rd, got;
    do_reset();
    pend = '{1'b0, 1'b0};
    a = '{32'h0, 32'h0}; d = '{32'h0, 32'h0}; s = '{4'h0, 4'h0};
    ins = 0;
    lw = 1'b1;
    for (int r = 0; r < 80; r++) begin
      do begin
        for (int i = 0; i < 2; i++) begin
          if (!pend[i] && $urandom_range(0, 2) != 0) begin
            pend[i] = 1'b1;
            a[i] = $urandom;
            d[i] = $urandom;
            s[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            if (i == 0) ins = 1'($urandom_range(0, 1));
          end
        end
      end while (!pend[0] && !pend[1]);
      @(negedge clk);
      m0_valid = pend[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = s[0]; m0_instr = ins;
      m1_valid = pend[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = s[1];
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      #1;
      total++;
      if ({busy, mem_valid, m0_ready, m1_ready} !== 4'b0) begin
        bad++; $display("FAIL rnd_idle r=%0d: got %b want 0000", r, {busy, mem_valid, m0_ready, m1_ready});
      end
      w = (pend[0] && pend[1]) ? ~lw : pend[1];
      lw = w;
      lat = $urandom_range(0, 10);
      to = (lat >= TO);
      done_k = to ? TO : lat + 1;
      rd = $urandom;
      exp_q.push_back(to ? ERR : rd);
      for (int k = 1; k <= done_k; k++) begin
        @(negedge clk);
        mem_ready = (k == lat + 1);
        mem_rdata = (k == lat + 1) ? rd : $urandom;
        #1;
        total++;
        if ({mem_valid, grant, mem_addr, mem_wdata, mem_wstrb, mem_instr} !==
            {1'b1, w, a[w], d[w], s[w], (w ? 1'b0 : ins)}) begin
          bad++; $display("FAIL rnd_bus r=%0d k=%0d: got g=%b a=%h d=%h s=%h i=%b want g=%b a=%h d=%h s=%h",
                          r, k, grant, mem_addr, mem_wdata, mem_wstrb, mem_instr, w, a[w], d[w], s[w]);
        end
        total++;
        if ({(w ? m1_ready : m0_ready), (w ? m0_ready : m1_ready), timeout_err} !==
            {(k == done_k), 1'b0, ((k == done_k) && to)}) begin
          bad++; $display("FAIL rnd_ready r=%0d k=%0d: got m0=%b m1=%b te=%b want winner=%0d done=%b to=%b",
                          r, k, m0_ready, m1_ready, timeout_err, w, (k == done_k), to);
        end
        if (k == done_k) begin
          got = w ? m1_rdata : m0_rdata;
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rnd_rdata r=%0d: got %h want <none queued>", r, got);
          end else begin
            if (got !== exp_q[0]) begin bad++; $display("FAIL rnd_rdata r=%0d: got %h want %h", r, got, exp_q[0]); end
            void'(exp_q.pop_front());
          end
        end
      end
      pend[w] = 1'b0;
    end
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write_routing();
    test_timeout();
    test_coincidence();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
- Two-master arbiter onto the single PicoRV32-style native memory port (valid/ready, addr/wdata/wstrb/rdata).
- Master 0 is the PicoRV32 core; master 1 is a secondary requester such as a program loader, DMA or debug port.
- Round-robin grant with a one-transaction lock.
- A per-transaction timeout watchdog keeps a hung slave from stalling the core forever.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in BUSY without mem_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned to the master on timeout.

Ports:
- clk  in  1  single clock, all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- m0_valid  in  1  master 0 request; held high with payload stable until m0_ready
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_ready  out  1  master 0 completion strobe, one cycle
- m0_rdata  out  32  master 0 read data, valid when m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, no instr flag; arbiter drives mem_instr=0 for master 1
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream instruction flag
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream byte strobes
- mem_ready  in  1  downstream completion
- mem_rdata  in  32  downstream read data
- grant  out  1  index of the master owning the bus; meaningful while busy=1
- busy  out  1  transaction in flight
- timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values: state=IDLE, busy=0, grant=0, last_grant=1 (master 0 wins the first tie), timeout counter=0, timeout_err=0. While in reset, mem_valid, m0_ready and m1_ready are 0, and mem_addr/wdata/wstrb/instr are 0.
- State machine with two states, IDLE and BUSY.
- IDLE: if no valid input, stay IDLE. If exactly one master is valid, grant it. If both are valid, grant the master != last_grant. On the clock edge, register grant and last_grant, clear the counter, go to BUSY.
- BUSY outputs: mem_valid=1; mem_addr/wdata/wstrb/instr are muxed combinationally from the granted master.
  - Arbitration latency: mem_valid rises the cycle after the first master valid is sampled.
  - The non-granted master sees ready=0.
- BUSY with mem_ready=1: in the same cycle, the granted master gets ready=1 and rdata=mem_rdata (combinational pass-through). Next state is IDLE. Result: one idle bubble between back-to-back transactions.
- BUSY with mem_ready=0: counter increments, saturating.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, the arbiter drives the granted master ready=1 with rdata=ERR_RDATA and pulses timeout_err=1 in that cycle.
  - mem_valid stays 1 in that cycle; next state is IDLE.
  - If mem_ready and the timeout coincide, mem_ready wins: real data is returned, no timeout_err.
- mem_ready while IDLE (late slave response) is ignored and not forwarded.
- Master drops valid while BUSY (protocol violation): grant is held until completion or timeout; the ready pulse is still issued.
- m*_rdata outside a ready cycle is don't-care; the implementation drives 0.
- Reset asserted mid-transaction: immediate return to reset values, no ready pulse, in-flight transaction abandoned.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Test Plan:
- Single master read: m0 reads 0x0000_0100, slave returns 0x1234_5678 after 3 cycles. Expect mem_valid 1 cycle after m0_valid; m0_ready for 1 cycle with rdata=0x1234_5678; m1_ready stays 0.
- Contention: m0 and m1 both valid from reset. Expect grant order 0,1,0,1 over four transactions, with one idle cycle between them; mem_instr mirrors m0_instr only during master 0 grants.
- Write routing: m1 writes 0xCAFE_F00D with wstrb=4'b0011 to 0x2000. Expect mem_addr, mem_wdata and mem_wstrb to match exactly and grant=1; on mem_ready, m1_ready=1.
- Timeout: TIMEOUT_CYCLES=8, slave never responds. Expect m0_ready and timeout_err high on the 8th BUSY cycle with rdata=0xDEAD_BEEF, then IDLE. A late mem_ready 3 cycles later produces no ready pulse.
- Coincidence: mem_ready on exactly the timeout cycle returns mem_rdata, with timeout_err=0.
- Reset mid-transaction: resetn low during BUSY forces mem_valid=0 immediately. After release with both masters valid, master 0 is granted first.
